add_seq: RTL and testbench
==========================

# add_seq

Parametrised, multi-cycle ripple adder/subtractor. It computes a W-bit sum one D-bit digit per clock through a single D-bit chunk adder, which trades latency for area against the fixed-width combinational adders. It sits between operand registers and result consumers, with a start/busy/done handshake. It adds a subtract mode, carry-out and signed-overflow flags, and held results.

## Interface
- W, 32: operand/result width; must be a positive multiple of D.
- D, 8: digit width processed per cycle; 1 ≤ D ≤ W.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when not busy.
- sub  input  1  0: s = a + b + ci; 1: s = a + ~b + ci (a−b requires ci=1).
- a  input  W  operand A, captured on accepted start.
- b  input  W  operand B, captured on accepted start.
- ci  input  1  carry-in, captured on accepted start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse: result valid.
- s  output  W  sum register, held until next accepted start.
- co  output  1  carry-out of bit W−1.
- ov  output  1  signed overflow (two's complement) of the W-bit operation.

## Operation
- N = W/D digits. Digit index idx counts 0..N−1, from least significant.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle.
- IDLE/DONE with start=1: capture a, b^{W{sub}}, ci into the operand and carry registers; clear s, co, ov; idx=0; go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN, each cycle:
  - The chunk adder sums digit idx of A, digit idx of B', and the carry register.
  - Write the result into digit idx of s; update the carry register.
  - idx = N−1: go to DONE; co = final carry; ov = (A[W−1] == B'[W−1]) && (s[W−1] != A[W−1]).
  - Otherwise idx++.
- start is ignored in RUN. Operand changes during RUN have no effect.
- s, co, and ov are stable from the DONE cycle until the next accepted start. They clear on that start.
- rst (any state, including mid-RUN): state=IDLE, idx=0, s=0, co=0, ov=0, busy=0, done=0, carry register=0.
- D=W degenerates to N=1: one RUN cycle.

## Timing
- start sampled high at edge T0 gives busy=1 during cycles T0+1..T0+N, and done=1 during cycle T0+N+1.
- Latency from start to done: N+1 cycles. Back-to-back throughput: one operation per N+1 cycles, because start is accepted during the DONE cycle.
- Partial s digits are visible during RUN and are not valid before done.
- No combinational path from inputs to outputs. The critical path is one D-bit ripple plus the digit mux.

## Structure
- Package add_pkg:
  - State enum: IDLE, RUN, DONE.
  - Default constants ADD_W=32, ADD_D=8.
  - Elaboration-time check W % D == 0.
- Sub-module addk: combinational D-bit adder with ports a, b, ci, s, co. It is instantiated once, and the digit mux feeds it.
- Top add_seq holds the FSM, idx counter, operand/carry/result registers, and flag logic.

## Test plan
- W=32, D=8, a=0x000000FF, b=0x00000001, ci=0, sub=0 -> busy for 4 cycles; done on the 5th cycle; s=0x00000100, co=0, ov=0.
- a=0xFFFFFFFF, b=0x00000001, ci=0 -> s=0x00000000, co=1, ov=0. Repeat with ci=1, b=0 -> same.
- a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, co=0, ov=1. Also a=0x80000000, b=0x80000000 -> s=0, co=1, ov=1.
- sub=1, ci=1, a=5, b=7 -> s=0xFFFFFFFE, co=0, ov=0. Also a=7, b=5 -> s=2, co=1.
- Handshake and reset:
  - start held high continuously -> done pulses every 5 cycles.
  - start pulses and operand changes during RUN are ignored.
  - rst asserted mid-RUN -> the next cycle shows all outputs at 0 in IDLE, and no done follows.
- Sweep D ∈ {1, 4, 32} with W=32 against a random reference model -> s/co/ov match, and latency = W/D+1.

Source files
------------

// File: rtl/add_pkg.sv
// Shared types and defaults for the digit-serial adder/subtractor.
package add_pkg;

    localparam int ADD_W = 32;
    localparam int ADD_D = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_e;

    // True when the width/digit pairing can be processed digit by digit.
    function automatic bit add_cfg_ok(input int w, input int d);
        return (d >= 1) && (d <= w) && ((w % d) == 0);
    endfunction

endpackage

// File: rtl/addk.sv
// Combinational D-bit chunk adder shared by every digit of the sequencer.
module addk
    import add_pkg::*;
#(
    parameter int D = ADD_D
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         ci,
    output logic [D-1:0] s,
    output logic         co
);

    // Widen by one bit so the carry-out falls out of the same addition.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, ci};

endmodule

// File: rtl/add_seq.sv
// Multi-cycle ripple adder/subtractor: one D-bit digit per clock through a
// single chunk adder, with a start/busy/done handshake and held results.
module add_seq
    import add_pkg::*;
#(
    parameter int W = ADD_W,
    parameter int D = ADD_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ov
);

    localparam int N     = W / D;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    if (!add_cfg_ok(W, D)) begin : g_cfg_bad
        $error("add_seq: W must be a positive multiple of D with 1 <= D <= W");
    end

    add_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;      // already inverted for subtract
    logic             carry_q, carry_d;
    logic [W-1:0]     s_q,     s_d;
    logic             co_q,    co_d;
    logic             ov_q,    ov_d;

    logic [D-1:0]     a_dig;
    logic [D-1:0]     b_dig;
    logic [D-1:0]     sum_k;
    logic             co_k;

    // Digit mux: select the current digit of each captured operand.
    assign a_dig = a_q[idx_q*D +: D];
    assign b_dig = b_q[idx_q*D +: D];

    addk #(.D(D)) u_addk (
        .a  (a_dig),
        .b  (b_dig),
        .ci (carry_q),
        .s  (sum_k),
        .co (co_k)
    );

    // Next-state logic: operand capture, digit write-back and flag update.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {W{sub}};
                    carry_d = ci;
                    s_d     = '0;
                    co_d    = 1'b0;
                    ov_d    = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d[idx_q*D +: D] = sum_k;
                carry_d           = co_k;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    co_d    = co_k;
                    // Top digit's MSB is the result sign bit being written now.
                    ov_d    = (a_q[W-1] == b_q[W-1]) && (sum_k[D-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq: arithmetic vectors at D = 8, 1, 4, 32 (W = 32),
// plus handshake, ignored-start and mid-run reset scenarios on the D = 8 unit.
module tb_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        start_v [4];
    logic        busy_w  [4];
    logic        done_w  [4];
    logic [31:0] s_w     [4];
    logic        co_w    [4];
    logic        ov_w    [4];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [10];
    int   lat_exp [4] = '{5, 33, 9, 2};   // W/D + 1 for D = 8, 1, 4, 32

    always #5 clk = ~clk;

    add_seq #(.W(32), .D(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_w[0]), .done(done_w[0]), .s(s_w[0]), .co(co_w[0]), .ov(ov_w[0])
    );
    add_seq #(.W(32), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_w[1]), .done(done_w[1]), .s(s_w[1]), .co(co_w[1]), .ov(ov_w[1])
    );
    add_seq #(.W(32), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_w[2]), .done(done_w[2]), .s(s_w[2]), .co(co_w[2]), .ov(ov_w[2])
    );
    add_seq #(.W(32), .D(32)) u_d32 (
        .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_w[3]), .done(done_w[3]), .s(s_w[3]), .co(co_w[3]), .ov(ov_w[3])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation on unit k; cycles counts negedges after the start edge.
    task automatic do_op(input int k, input int v);
        int cycles;
        @(negedge clk);
        a  = vecs[v].a;
        b  = vecs[v].b;
        ci = vecs[v].ci;
        sub = vecs[v].sub;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        cycles = 1;
        while (!done_w[k] && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check($sformatf("lat k%0d v%0d", k, v), 64'(cycles), 64'(lat_exp[k]));
        check($sformatf("s k%0d v%0d", k, v), 64'(s_w[k]), 64'(vecs[v].s));
        check($sformatf("co k%0d v%0d", k, v), 64'(co_w[k]), 64'(vecs[v].co));
        check($sformatf("ov k%0d v%0d", k, v), 64'(ov_w[k]), 64'(vecs[v].ov));
        @(negedge clk);
        check($sformatf("done_pulse k%0d v%0d", k, v), 64'(done_w[k]), 64'd0);
        check($sformatf("idle_busy k%0d v%0d", k, v), 64'(busy_w[k]), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int cycles;
        int n_done;
        int last_done;

        //           a             b             ci    sub   s             co    ov
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[6] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
        vecs[7] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[8] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0};
        vecs[9] = '{32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};

        rst = 1'b1;
        sub = 1'b0;
        a   = '0;
        b   = '0;
        ci  = 1'b0;
        for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy_w[0]), 64'd0);
        check("rst done", 64'(done_w[0]), 64'd0);
        check("rst s",    64'(s_w[0]),    64'd0);
        check("rst co",   64'(co_w[0]),   64'd0);
        check("rst ov",   64'(ov_w[0]),   64'd0);
        rst = 1'b0;

        // Arithmetic vectors across every digit width.
        for (int k = 0; k < 4; k++)
            for (int v = 0; v < 10; v++)
                do_op(k, v);

        // start held high: one done pulse every 5 cycles.
        @(negedge clk);
        a = 32'd1; b = 32'd1; ci = 1'b0; sub = 1'b0;
        start_v[0] = 1'b1;
        n_done = 0;
        last_done = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done_w[0]) begin
                n_done++;
                check($sformatf("hold gap %0d", n_done), 64'(c - last_done), 64'd5);
                check($sformatf("hold s %0d", n_done), 64'(s_w[0]), 64'd2);
                last_done = c;
            end
        end
        start_v[0] = 1'b0;
        check("hold n_done", 64'(n_done), 64'd6);
        repeat (2) @(negedge clk);
        check("hold idle", 64'(busy_w[0] | done_w[0]), 64'd0);

        // start pulse and operand changes during RUN are ignored.
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; ci = 1'b0; sub = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cycles = 1;
        @(negedge clk);
        cycles++;
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; ci = 1'b1; sub = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        cycles++;
        start_v[0] = 1'b0;
        while (!done_w[0] && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("ign lat", 64'(cycles), 64'd5);
        check("ign s",   64'(s_w[0]), 64'h23456789);
        check("ign co",  64'(co_w[0]), 64'd0);
        @(negedge clk);
        check("ign no_restart", 64'(busy_w[0]), 64'd0);

        // Reset mid-RUN: everything clears and no done follows.
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; ci = 1'b1; sub = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("mid busy_before", 64'(busy_w[0]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid busy", 64'(busy_w[0]), 64'd0);
        check("mid done", 64'(done_w[0]), 64'd0);
        check("mid s",    64'(s_w[0]),    64'd0);
        check("mid co",   64'(co_w[0]),   64'd0);
        check("mid ov",   64'(ov_w[0]),   64'd0);
        rst = 1'b0;
        n_done = 0;
        cycles = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_w[0]) n_done++;
            if (busy_w[0]) cycles++;
        end
        check("mid no_done", 64'(n_done), 64'd0);
        check("mid no_busy", 64'(cycles), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
